// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_pkg
//  Description : Shared widths, FSM state encodings and port indices for the
//                data-memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

   localparam int DMEM_ADDR_W = 10;
   localparam int DMEM_DATA_W = 32;

   // Arbiter FSM: remembers which port owned the memory in the previous cycle
   localparam int ST_W = 2;
   typedef logic [ST_W-1:0] arb_state_t;
   localparam arb_state_t ST_IDLE = 2'd0;
   localparam arb_state_t ST_OWN0 = 2'd1;
   localparam arb_state_t ST_OWN1 = 2'd2;

   // Port indices (0 = CPU load/store unit, 1 = loader/debug master)
   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   // Ownership state that results from granting the given port
   function automatic arb_state_t own_state(input logic port);
      return (port == PORT1) ? ST_OWN1 : ST_OWN0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_req_if / dmem_mem_if
//  Description : Requester-side handshake bundle and memory-side pin bundle
//                of the data-memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_req_if
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W = DMEM_ADDR_W,
   parameter int DATA_W = DMEM_DATA_W
) ();
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

interface dmem_mem_if
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W = DMEM_ADDR_W,
   parameter int DATA_W = DMEM_DATA_W
) ();
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;

   modport master (output we, addr, wdata, input rdata);
   modport slave  (input we, addr, wdata, output rdata);
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter_rd_return.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_rd_return
//  Description : Per-port read-return register. Captures the memory's
//                combinational read data on a granted read and flags it valid
//                for exactly the following cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_rd_return
   import dmem_arbiter_pkg::*;
#(
   parameter int DATA_W = DMEM_DATA_W
) (
   input  wire logic              clk,
   input  wire logic              reset,
   input  wire logic              gnt_i,
   input  wire logic              we_i,
   input  wire logic [DATA_W-1:0] mem_rdata_i,
   output logic                   rvalid_o,
   output logic [DATA_W-1:0]      rdata_o
);

   logic              rvalid_q;
   logic [DATA_W-1:0] rdata_q;

   // Capture read data on a granted read; rdata holds between reads
   always_ff @(posedge clk) begin
      if (reset) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= gnt_i & ~we_i;
         if (gnt_i && !we_i) begin
            rdata_q <= mem_rdata_i;
         end
      end
   end

   // A read in flight when reset arrives is dropped, never reported
   always_comb begin
      rvalid_o = rvalid_q & ~reset;
      rdata_o  = rdata_q;
   end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-requester arbiter for the single-port 1024x32 data
//                memory. One access per cycle, registered read return, and a
//                burst limit bounding how long one port can starve the other.
//                Build option DMEM_ARB_RR_EN: round-robin tie-break from idle
//                (default build: port 0 wins ties from idle).
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W    = DMEM_ADDR_W,
   parameter int DATA_W    = DMEM_DATA_W,
   parameter int MAX_BURST = 4
) (
   input  wire logic  clk,
   input  wire logic  reset,
   dmem_req_if.slave  r0,
   dmem_req_if.slave  r1,
   dmem_mem_if.master mem
);

   localparam int               CNT_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

   arb_state_t       state_q, state_d;
   logic [CNT_W-1:0] burst_q, burst_d;
   logic             grant_any;
   logic             grant_port;
   logic             gnt0, gnt1;

`ifdef DMEM_ARB_RR_EN
   logic             last_owner_q;
`endif

   // State register: owner of the previous cycle and its repeat-grant count
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         burst_q      <= '0;
`ifdef DMEM_ARB_RR_EN
         last_owner_q <= PORT1;
`endif
      end else begin
         state_q      <= state_d;
         burst_q      <= burst_d;
`ifdef DMEM_ARB_RR_EN
         if (grant_any) begin
            last_owner_q <= grant_port;
         end
`endif
      end
   end

   // Next-state: pick the winner for this cycle and update the burst count
   always_comb begin
      grant_any  = 1'b0;
      grant_port = PORT0;
      case (state_q)
         ST_OWN0: begin
            if (r0.req && (!r1.req || burst_q < BURST_LAST)) begin
               grant_any  = 1'b1;
               grant_port = PORT0;
            end else if (r1.req) begin
               grant_any  = 1'b1;
               grant_port = PORT1;
            end
         end
         ST_OWN1: begin
            if (r1.req && (!r0.req || burst_q < BURST_LAST)) begin
               grant_any  = 1'b1;
               grant_port = PORT1;
            end else if (r0.req) begin
               grant_any  = 1'b1;
               grant_port = PORT0;
            end
         end
         default: begin
            if (r0.req && r1.req) begin
               grant_any  = 1'b1;
`ifdef DMEM_ARB_RR_EN
               grant_port = ~last_owner_q;
`else
               grant_port = PORT0;
`endif
            end else if (r0.req) begin
               grant_any  = 1'b1;
               grant_port = PORT0;
            end else if (r1.req) begin
               grant_any  = 1'b1;
               grant_port = PORT1;
            end
         end
      endcase

      state_d = grant_any ? own_state(grant_port) : ST_IDLE;

      // Repeat grant to the same owner counts up (saturating); anything else restarts
      burst_d = '0;
      if (grant_any && state_q == own_state(grant_port)) begin
         burst_d = (burst_q == BURST_LAST) ? burst_q : burst_q + CNT_W'(1);
      end
   end

   // Outputs: grant strobes and the winner's request steered onto the memory pins
   always_comb begin
      gnt0      = grant_any & (grant_port == PORT0) & ~reset;
      gnt1      = grant_any & (grant_port == PORT1) & ~reset;
      r0.gnt    = gnt0;
      r1.gnt    = gnt1;
      mem.we    = 1'b0;
      mem.addr  = {ADDR_W{1'b0}};
      mem.wdata = {DATA_W{1'b0}};
      if (gnt0) begin
         mem.we    = r0.we;
         mem.addr  = r0.addr;
         mem.wdata = r0.wdata;
      end else if (gnt1) begin
         mem.we    = r1.we;
         mem.addr  = r1.addr;
         mem.wdata = r1.wdata;
      end
   end

   dmem_rd_return #(.DATA_W(DATA_W)) u_rd_ret0 (
      .clk         (clk),
      .reset       (reset),
      .gnt_i       (gnt0),
      .we_i        (r0.we),
      .mem_rdata_i (mem.rdata),
      .rvalid_o    (r0.rvalid),
      .rdata_o     (r0.rdata)
   );

   dmem_rd_return #(.DATA_W(DATA_W)) u_rd_ret1 (
      .clk         (clk),
      .reset       (reset),
      .gnt_i       (gnt1),
      .we_i        (r1.we),
      .mem_rdata_i (mem.rdata),
      .rvalid_o    (r1.rvalid),
      .rdata_o     (r1.rdata)
   );

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter: directed scenarios plus
//                randomized traffic against a cycle-level reference model, with
//                read returns checked by a scoreboard monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

   localparam int AW        = 10;
   localparam int DW        = 32;
   localparam int MAX_BURST = 4;

   logic clk;
   logic reset;

   dmem_req_if #(.ADDR_W(AW), .DATA_W(DW)) r0_if ();
   dmem_req_if #(.ADDR_W(AW), .DATA_W(DW)) r1_if ();
   dmem_mem_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAX_BURST)) dut (
      .clk   (clk),
      .reset (reset),
      .r0    (r0_if),
      .r1    (r1_if),
      .mem   (mem_if)
   );

   // Memory device: combinational read, write at the rising edge
   logic [DW-1:0] mem_arr [1024];
   assign mem_if.rdata = mem_arr[mem_if.addr];
   always @(posedge clk) begin
      if (mem_if.we) mem_arr[mem_if.addr] <= mem_if.wdata;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counters and scoreboard
   int            n_chk  = 0;
   int            n_pass = 0;
   logic [DW-1:0] exp_q0[$];
   logic [DW-1:0] exp_q1[$];
   logic [DW-1:0] ref_mem [1024];

   // Reference model state: previous owner (-1 none), its run length, last port granted
   int prev_owner = -1;
   int run_len    = 0;
   int last_gnt   = 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
   endtask

   // Arbitration rules: the previous owner keeps the memory until it stops
   // asking or has taken MAX_BURST grants in a row while the other waits.
   function automatic int predict(input bit q0, input bit q1);
      bit own_q, oth_q;
      if (prev_owner >= 0) begin
         own_q = (prev_owner == 0) ? q0 : q1;
         oth_q = (prev_owner == 0) ? q1 : q0;
         if (own_q && (!oth_q || run_len < MAX_BURST)) return prev_owner;
         if (oth_q) return 1 - prev_owner;
         return -1;
      end
      if (q0 && q1) begin
`ifdef DMEM_ARB_RR_EN
         return 1 - last_gnt;
`else
         return 0;
`endif
      end
      if (q0) return 0;
      if (q1) return 1;
      return -1;
   endfunction

   // Read-return monitor: every expected return must appear exactly one cycle after its grant
   always @(negedge clk) begin
      if (reset) begin
         if (r0_if.rvalid || r1_if.rvalid || exp_q0.size() > 0 || exp_q1.size() > 0)
            chk("rvalid_during_reset", {r0_if.rvalid, r1_if.rvalid}, 2'b00);
      end else begin
         if (exp_q0.size() > 0) begin
            chk("r0_rvalid", r0_if.rvalid, 1'b1);
            chk("r0_rdata", r0_if.rdata, exp_q0.pop_front());
         end else if (r0_if.rvalid) begin
            chk("r0_rvalid_spurious", r0_if.rvalid, 1'b0);
         end
         if (exp_q1.size() > 0) begin
            chk("r1_rvalid", r1_if.rvalid, 1'b1);
            chk("r1_rdata", r1_if.rdata, exp_q1.pop_front());
         end else if (r1_if.rvalid) begin
            chk("r1_rvalid_spurious", r1_if.rvalid, 1'b0);
         end
      end
   end

   // One clock of stimulus: drive, then compare grant and memory pins with the model
   task automatic cycle(input bit rst,
                        input bit q0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input bit q1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        output int obs, output int exp_g);
      logic [AW+DW:0] exp_mem;
      @(posedge clk);
      #1;
      reset = rst;
      r0_if.req = q0; r0_if.we = w0; r0_if.addr = a0; r0_if.wdata = d0;
      r1_if.req = q1; r1_if.we = w1; r1_if.addr = a1; r1_if.wdata = d1;
      @(negedge clk);
      #1;
      exp_g = rst ? -1 : predict(q0, q1);
      obs   = (r0_if.gnt && r1_if.gnt) ? 2 : r0_if.gnt ? 0 : r1_if.gnt ? 1 : -1;
      chk("grant", obs, exp_g);
      if (exp_g == 0)      exp_mem = {w0, a0, d0};
      else if (exp_g == 1) exp_mem = {w1, a1, d1};
      else                 exp_mem = '0;
      chk("mem_pins", {mem_if.we, mem_if.addr, mem_if.wdata}, exp_mem);
      if (exp_g >= 0) begin
         if (exp_mem[AW+DW]) ref_mem[exp_mem[AW+DW-1:DW]] = exp_mem[DW-1:0];
         else if (exp_g == 0) exp_q0.push_back(ref_mem[a0]);
         else                 exp_q1.push_back(ref_mem[a1]);
      end
      if (rst) begin
         exp_q0.delete();
         exp_q1.delete();
         prev_owner = -1;
         run_len    = 0;
         last_gnt   = 1;
      end else begin
         run_len    = (exp_g >= 0 && exp_g == prev_owner) ? run_len + 1 : ((exp_g >= 0) ? 1 : 0);
         prev_owner = exp_g;
         if (exp_g >= 0) last_gnt = exp_g;
      end
   endtask

   task automatic idle(input int n);
      int o, e;
      for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, '0, 0, 0, '0, '0, o, e);
   endtask

   int pat [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

   initial begin
      int o, e, waitc, tie_exp;
      bit got;
      bit q0, w0, q1, w1;
      logic [AW-1:0] a0, a1;
      logic [DW-1:0] d0, d1;

      for (int i = 0; i < 1024; i++) begin
         mem_arr[i] = 32'hA5A5_0000 ^ (i * 32'h0001_0203);
         ref_mem[i] = 32'hA5A5_0000 ^ (i * 32'h0001_0203);
      end
      reset = 1'b1;
      r0_if.req = 0; r0_if.we = 0; r0_if.addr = '0; r0_if.wdata = '0;
      r1_if.req = 0; r1_if.we = 0; r1_if.addr = '0; r1_if.wdata = '0;

      // Reset held with both ports requesting
      cycle(1, 1, 0, 10'd1, '0, 1, 0, 10'd2, '0, o, e);
      cycle(1, 1, 0, 10'd1, '0, 1, 0, 10'd2, '0, o, e);
      chk("reset_r0_rdata", r0_if.rdata, 32'h0);
      chk("reset_r1_rdata", r1_if.rdata, 32'h0);
      chk("reset_rvalid", {r0_if.rvalid, r1_if.rvalid}, 2'b00);

      // Single write then read of address 5 on port 0
      cycle(0, 1, 1, 10'd5, 32'hDEADBEEF, 0, 0, '0, '0, o, e);
      cycle(0, 1, 0, 10'd5, '0, 0, 0, '0, '0, o, e);
      idle(1);
      chk("wr_rd_r0_rdata", r0_if.rdata, 32'hDEADBEEF);
      chk("wr_rd_r1_quiet", {r1_if.rvalid, r1_if.gnt}, 2'b00);

      // Contention from idle: 4 / 4 / 4 alternation
      idle(1);
      for (int k = 0; k < 12; k++) begin
         cycle(0, 1, 0, 10'(k), '0, 1, 0, 10'(k + 100), '0, o, e);
         chk("contention_pattern", o, pat[k]);
      end

      // Tie-break from idle after port 0 was the last one granted
      idle(1);
      cycle(0, 1, 0, 10'd7, '0, 0, 0, '0, '0, o, e);
      idle(1);
`ifdef DMEM_ARB_RR_EN
      tie_exp = 1;
`else
      tie_exp = 0;
`endif
      cycle(0, 1, 0, 10'd8, '0, 1, 0, 10'd9, '0, o, e);
      chk("tie_break", o, tie_exp);

      // Reset right after a granted port-1 read
      idle(1);
      cycle(0, 0, 0, '0, '0, 1, 0, 10'd33, '0, o, e);
      chk("pre_reset_r1_gnt", o, 1);
      cycle(1, 1, 0, 10'd3, '0, 1, 0, 10'd4, '0, o, e);
      chk("reset_drops_r1_rvalid", r1_if.rvalid, 1'b0);
      cycle(1, 1, 0, 10'd3, '0, 1, 0, 10'd4, '0, o, e);
      cycle(0, 1, 0, 10'd3, '0, 1, 0, 10'd4, '0, o, e);
      chk("post_reset_winner", o, 0);

      // Starvation bound: port 0 streams, port 1 pulses a request
      idle(1);
      for (int k = 0; k < 6; k++) cycle(0, 1, 0, 10'(k), '0, 0, 0, '0, '0, o, e);
      waitc = 0; got = 0;
      for (int k = 0; k < 10 && !got; k++) begin
         cycle(0, 1, 0, 10'(k), '0, 1, 0, 10'd50, '0, o, e);
         waitc++;
         if (o == 1) got = 1;
      end
      chk("starve_after_long_run", got ? waitc : 99, 1);
      idle(1);
      cycle(0, 1, 0, 10'd1, '0, 0, 0, '0, '0, o, e);
      waitc = 0; got = 0;
      for (int k = 0; k < 10 && !got; k++) begin
         cycle(0, 1, 0, 10'(k), '0, 1, 0, 10'd51, '0, o, e);
         waitc++;
         if (o == 1) got = 1;
      end
      chk("starve_fresh_run", got ? waitc : 99, MAX_BURST);

      // Randomized traffic; requests held until granted, small address range for hazards
      q0 = 0; w0 = 0; a0 = '0; d0 = '0;
      q1 = 0; w1 = 0; a1 = '0; d1 = '0;
      for (int k = 0; k < 500; k++) begin
         bit rst;
         rst = ($urandom_range(0, 79) == 0);
         cycle(rst, q0, w0, a0, d0, q1, w1, a1, d1, o, e);
         if (!q0 || e == 0 || rst) begin
            q0 = ($urandom_range(0, 3) != 0); w0 = $urandom_range(0, 1);
            a0 = 10'($urandom_range(0, 15)); d0 = $urandom;
         end
         if (!q1 || e == 1 || rst) begin
            q1 = ($urandom_range(0, 2) != 0); w1 = $urandom_range(0, 1);
            a1 = 10'($urandom_range(0, 15)); d1 = $urandom;
         end
      end

      idle(2);
      chk("scoreboard_drained", exp_q0.size() + exp_q1.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
